// File: rtl/prog_rom_loader_pkg.sv
// Shared types and constants for the Hack instruction memory with boot loader.
package hack_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 15;

  localparam logic [15:0] HACK_NOP = 16'h0000;

endpackage

// File: rtl/prog_rom_loader_if.sv
// Fetch port plus boot-load stream; master is the host/CPU side, slave is the memory.
interface prog_rom_loader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);

  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] out;
  logic              load_start;
  logic [DATA_W-1:0] load_data;
  logic              load_valid;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              busy;
  logic [ADDR_W:0]   load_count;
  logic              overflow;

  modport master (
    output address, load_start, load_data, load_valid, load_last,
    input  out, load_ready, load_done, busy, load_count, overflow
  );

  modport slave (
    input  address, load_start, load_data, load_valid, load_last,
    output out, load_ready, load_done, busy, load_count, overflow
  );

endinterface

// File: rtl/prog_rom_loader_rom_array.sv
// Simple dual-port RAM: synchronous write, registered read with synchronous output clear.
module rom_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32768,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_clr,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_clr) begin
      rd_data_d = '0;
    end else begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/prog_rom_loader.sv
// Hack instruction memory: CPU fetch port with 1- or 2-cycle latency and a
// sequential boot-load stream that holds the CPU off until the program is in.
module prog_rom_loader
  import hack_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 2 ** ADDR_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  prog_rom_loader_if.slave  bus
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              beat_s;
  logic              wr_en_s;
  logic              rd_clr_s;
  logic [DATA_W-1:0] ram_rd_s;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    beat_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d    = LOAD;
          ptr_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        beat_s = bus.load_valid && ready_q;
        if (beat_s) begin
          ptr_d   = ptr_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
          if (bus.load_last) begin
            state_d = DONE;
          end else if ((count_q + CNT_ONE) == DEPTH_C) begin
            state_d    = DONE;
            overflow_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake/status outputs are registered decodes of the next state.
    ready_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // A beat coinciding with reset is dropped, so reset fully wins.
  assign wr_en_s  = beat_s && !reset;
  assign rd_clr_s = reset || busy_q || ({1'b0, bus.address} >= DEPTH_C);

  rom_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_rom_array (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (ptr_q[IDX_W-1:0]),
    .wr_data (bus.load_data),
    .rd_clr  (rd_clr_s),
    .rd_addr (bus.address[IDX_W-1:0]),
    .rd_data (ram_rd_s)
  );

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] out_q;

    always_comb begin
      out_d = '0;
      if (reset || busy_q) begin
        out_d = DATA_W'(HACK_NOP);
      end else begin
        out_d = ram_rd_s;
      end
    end

    always_ff @(posedge clk) begin
      out_q <= out_d;
    end

    assign bus.out = out_q;
  end else begin : g_lat1
    assign bus.out = ram_rd_s;
  end

  assign bus.load_ready = ready_q;
  assign bus.load_done  = done_q;
  assign bus.busy       = busy_q;
  assign bus.load_count = count_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_prog_rom_loader.sv
// Directed bench: READ_LAT=1 and READ_LAT=2 full-size memories sharing stimulus,
// plus a DEPTH=8 memory for the overflow path.
module tb_prog_rom_loader;

  logic clk = 1'b0;
  logic reset;
  int   n_vec;
  int   n_miscomp;

  always #5 clk = ~clk;

  prog_rom_loader_if #(.DATA_W(16), .ADDR_W(15)) bus1 ();
  prog_rom_loader_if #(.DATA_W(16), .ADDR_W(15)) bus2 ();
  prog_rom_loader_if #(.DATA_W(16), .ADDR_W(3))  bus3 ();

  assign bus2.address    = bus1.address;
  assign bus2.load_start = bus1.load_start;
  assign bus2.load_data  = bus1.load_data;
  assign bus2.load_valid = bus1.load_valid;
  assign bus2.load_last  = bus1.load_last;

  prog_rom_loader #(.DATA_W(16), .ADDR_W(15), .READ_LAT(1)) u_dut_lat1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  prog_rom_loader #(.DATA_W(16), .ADDR_W(15), .READ_LAT(2)) u_dut_lat2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  prog_rom_loader #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .READ_LAT(1)) u_dut_ovf (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  logic [15:0] prog [4];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscomp++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat1(input logic [15:0] d, input logic last);
    bus1.load_valid = 1'b1;
    bus1.load_data  = d;
    bus1.load_last  = last;
    tick();
    bus1.load_valid = 1'b0;
    bus1.load_last  = 1'b0;
  endtask

  task automatic read1(input string tag, input logic [14:0] a, input logic [15:0] exp);
    bus1.address = a;
    tick();
    check_val(tag, {16'h0000, bus1.out}, {16'h0000, exp});
  endtask

  initial begin
    n_vec     = 0;
    n_miscomp = 0;
    prog[0] = 16'h0010;
    prog[1] = 16'hEC10;
    prog[2] = 16'h0005;
    prog[3] = 16'hE308;

    reset = 1'b1;
    bus1.address = 15'd0; bus1.load_start = 1'b0; bus1.load_data = 16'h0000;
    bus1.load_valid = 1'b0; bus1.load_last = 1'b0;
    bus3.address = 3'd0; bus3.load_start = 1'b0; bus3.load_data = 16'h0000;
    bus3.load_valid = 1'b0; bus3.load_last = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check_val("rst_out_lat1", {16'h0000, bus1.out}, 32'd0);
    check_val("rst_out_lat2", {16'h0000, bus2.out}, 32'd0);
    check_val("rst_busy", {31'd0, bus1.busy}, 32'd0);
    check_val("rst_ready", {31'd0, bus1.load_ready}, 32'd0);
    check_val("rst_done", {31'd0, bus1.load_done}, 32'd0);
    check_val("rst_count", {16'h0000, bus1.load_count}, 32'd0);
    check_val("rst_ovf", {31'd0, bus1.overflow}, 32'd0);
    bus1.address = 15'd0;
    tick();
    check_val("idle_busy", {31'd0, bus1.busy}, 32'd0);
    check_val("idle_ready", {31'd0, bus1.load_ready}, 32'd0);

    // Basic load with a 3-cycle stall and an ignored load_start mid-load.
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    check_val("load_busy", {31'd0, bus1.busy}, 32'd1);
    check_val("load_ready", {31'd0, bus1.load_ready}, 32'd1);
    beat1(prog[0], 1'b0);
    beat1(prog[1], 1'b0);
    check_val("beat2_count", {16'h0000, bus1.load_count}, 32'd2);
    bus1.address    = 15'd1;
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    check_val("mask_lat1", {16'h0000, bus1.out}, 32'd0);
    check_val("gap1_count", {16'h0000, bus1.load_count}, 32'd2);
    tick();
    check_val("mask_lat2", {16'h0000, bus2.out}, 32'd0);
    tick();
    check_val("gap3_count", {16'h0000, bus1.load_count}, 32'd2);
    beat1(prog[2], 1'b0);
    beat1(prog[3], 1'b1);
    check_val("done_pulse", {31'd0, bus1.load_done}, 32'd1);
    check_val("done_busy", {31'd0, bus1.busy}, 32'd1);
    check_val("done_ready", {31'd0, bus1.load_ready}, 32'd0);
    check_val("done_count", {16'h0000, bus1.load_count}, 32'd4);
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    check_val("post_done", {31'd0, bus1.load_done}, 32'd0);
    check_val("post_busy", {31'd0, bus1.busy}, 32'd0);
    check_val("post_ovf", {31'd0, bus1.overflow}, 32'd0);
    check_val("post_count", {16'h0000, bus1.load_count}, 32'd4);

    for (int i = 0; i < 4; i++) begin
      bus1.address = 15'(i);
      tick();
      check_val($sformatf("rd_lat1_%0d", i), {16'h0000, bus1.out}, {16'h0000, prog[i]});
      if (i > 0) begin
        check_val($sformatf("rd_lat2_%0d", i - 1), {16'h0000, bus2.out}, {16'h0000, prog[i-1]});
      end
    end
    tick();
    check_val("rd_lat2_3", {16'h0000, bus2.out}, {16'h0000, prog[3]});

    // Overflow on the DEPTH=8 build; valid stays high through DONE.
    bus3.load_start = 1'b1;
    tick();
    bus3.load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        check_val("ovf_ready_pre", {31'd0, bus3.load_ready}, 32'd1);
        check_val("ovf_flag_pre", {31'd0, bus3.overflow}, 32'd0);
      end
      bus3.load_valid = 1'b1;
      bus3.load_data  = 16'hA000 + 16'(i);
      tick();
    end
    bus3.load_data = 16'hDEAD;
    check_val("ovf_ready", {31'd0, bus3.load_ready}, 32'd0);
    check_val("ovf_flag", {31'd0, bus3.overflow}, 32'd1);
    check_val("ovf_done", {31'd0, bus3.load_done}, 32'd1);
    check_val("ovf_count", {28'd0, bus3.load_count}, 32'd8);
    tick();
    bus3.load_valid = 1'b0;
    check_val("ovf_count_hold", {28'd0, bus3.load_count}, 32'd8);
    check_val("ovf_busy", {31'd0, bus3.busy}, 32'd0);
    check_val("ovf_sticky", {31'd0, bus3.overflow}, 32'd1);
    bus3.address = 3'd0;
    tick();
    check_val("ovf_rd0", {16'h0000, bus3.out}, 32'h0000A000);
    bus3.address = 3'd7;
    tick();
    check_val("ovf_rd7", {16'h0000, bus3.out}, 32'h0000A007);

    // Reset mid-load, with a beat offered on the reset edge.
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    beat1(16'h1111, 1'b0);
    beat1(16'h2222, 1'b0);
    bus1.load_valid = 1'b1;
    bus1.load_data  = 16'h3333;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus1.load_valid = 1'b0;
    check_val("mid_rst_busy", {31'd0, bus1.busy}, 32'd0);
    check_val("mid_rst_ready", {31'd0, bus1.load_ready}, 32'd0);
    check_val("mid_rst_count", {16'h0000, bus1.load_count}, 32'd0);
    check_val("mid_rst_ovf", {31'd0, bus1.overflow}, 32'd0);
    check_val("mid_rst_ovf8", {31'd0, bus3.overflow}, 32'd0);
    read1("mid_rd0", 15'd0, 16'h1111);
    read1("mid_rd1", 15'd1, 16'h2222);
    read1("mid_rd2", 15'd2, 16'h0005);

    // Reset beats load_start; then a one-word program restarts at address 0.
    reset = 1'b1;
    bus1.load_start = 1'b1;
    tick();
    reset = 1'b0;
    bus1.load_start = 1'b0;
    check_val("rst_vs_start", {31'd0, bus1.busy}, 32'd0);
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    beat1(16'hABCD, 1'b1);
    check_val("one_done", {31'd0, bus1.load_done}, 32'd1);
    check_val("one_count", {16'h0000, bus1.load_count}, 32'd1);
    tick();
    check_val("one_busy", {31'd0, bus1.busy}, 32'd0);
    read1("one_rd0", 15'd0, 16'hABCD);
    read1("one_rd1", 15'd1, 16'h2222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule
